// File: rtl/servo_pwm_multi_if.sv
// Target-position write port for servo_pwm_multi: valid/ready handshake
// carrying a channel index and an 8-bit position.
interface servo_pwm_multi_if #(
    parameter int CH_W = 2
);
    logic            wr_valid;
    logic            wr_ready;
    logic [CH_W-1:0] wr_ch;
    logic [7:0]      wr_pos;

    modport master (output wr_valid, output wr_ch, output wr_pos, input wr_ready);
    modport slave  (input wr_valid, input wr_ch, input wr_pos, output wr_ready);
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator. All channels share one frame
// counter; each channel slews its current position toward a written target
// once per frame and emits a pulse of MIN_PULSE + pos*STEP_CYCLES cycles
// aligned to counter 0.
module servo_pwm_multi #(
    parameter int NUM_CH        = 4,
    parameter int PERIOD_CYCLES = 200000,
    parameter int MIN_PULSE     = 10000,
    parameter int STEP_CYCLES   = 40,
    parameter int CH_W          = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 ena_i,
    input  logic [7:0]           slew_i,
    servo_pwm_multi_if.slave     wr_if,
    output logic [NUM_CH-1:0]    pwm_out_o,
    output logic                 frame_start_o,
    output logic [NUM_CH-1:0]    settled_o
);

    localparam int CNT_W = $clog2(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

    // Elaboration-time legality checks: the widest pulse must end inside the frame.
    if (MIN_PULSE + 255 * STEP_CYCLES >= PERIOD_CYCLES) begin : g_bad_timing
        $error("servo_pwm_multi: MIN_PULSE + 255*STEP_CYCLES must be < PERIOD_CYCLES");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("servo_pwm_multi: NUM_CH must be in 1..16");
    end
    if ((1 << CH_W) < NUM_CH) begin : g_bad_ch_w
        $error("servo_pwm_multi: CH_W too narrow for NUM_CH");
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_q;
    logic [7:0]        tgt_q [NUM_CH];
    logic [7:0]        cur_q [NUM_CH];
    logic [7:0]        cur_d [NUM_CH];
    logic [31:0]       thr   [NUM_CH];
    logic [NUM_CH-1:0] pwm_q;
    logic              fs_q;
    logic [NUM_CH-1:0] settled_q;
    logic              boundary;
    logic              wr_fire;
    logic              wr_hit;
    logic [31:0]       cnt_ext;

    // The last cycle of a frame is reserved for the slew update, so writes
    // are refused there and can never race it.
    assign boundary       = ena_i && (cnt_q == LAST);
    assign wr_if.wr_ready = rdy_q & ~boundary;
    assign wr_fire        = wr_if.wr_valid & wr_if.wr_ready;
    assign wr_hit         = wr_fire && (int'(wr_if.wr_ch) < NUM_CH);
    assign cnt_d          = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    assign cnt_ext        = 32'(cnt_q);

    // Next position per channel (slew toward target) and pulse thresholds.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cur_d[i] = cur_q[i];
            thr[i]   = 32'(MIN_PULSE) + 32'(cur_q[i]) * 32'(STEP_CYCLES);
            if (cur_q[i] != tgt_q[i]) begin
                if (tgt_q[i] > cur_q[i]) begin
                    if (slew_i == 8'd0 || (tgt_q[i] - cur_q[i]) <= slew_i)
                        cur_d[i] = tgt_q[i];
                    else
                        cur_d[i] = cur_q[i] + slew_i;
                end else begin
                    if (slew_i == 8'd0 || (cur_q[i] - tgt_q[i]) <= slew_i)
                        cur_d[i] = tgt_q[i];
                    else
                        cur_d[i] = cur_q[i] - slew_i;
                end
            end
        end
    end

    // Frame counter, registered pulse outputs and once-per-frame position update.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            pwm_q <= '0;
            fs_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cur_q[i] <= 8'd0;
        end else if (ena_i) begin
            cnt_q <= cnt_d;
            fs_q  <= (cnt_q == '0);
            for (int i = 0; i < NUM_CH; i++) pwm_q[i] <= (cnt_ext < thr[i]);
            if (cnt_q == LAST) begin
                for (int i = 0; i < NUM_CH; i++) cur_q[i] <= cur_d[i];
            end
        end
    end

    // Ready comes up one edge after reset release. Writes are accepted even
    // with ena low so a completed handshake never loses data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdy_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) tgt_q[i] <= 8'd0;
        end else begin
            rdy_q <= 1'b1;
            if (wr_hit) tgt_q[wr_if.wr_ch] <= wr_if.wr_pos;
        end
    end

    // Per-channel settled flag, one cycle behind the position/target compare.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            settled_q <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) settled_q[i] <= (cur_q[i] == tgt_q[i]);
        end
    end

    assign pwm_out_o     = pwm_q;
    assign frame_start_o = fs_q;
    assign settled_o     = settled_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi. Stimulus pushes expected pulse widths and frame
// periods into queues; a monitor measures each pulse and frame and compares.
module tb_servo_pwm_multi;

    localparam int P = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic [7:0] slew;
    logic [3:0] pwm;
    logic       fs;
    logic [3:0] settled;
    logic [2:0] pwm3;
    logic       fs3;
    logic [2:0] settled3;

    int vectors = 0;
    int miscompares = 0;

    int exp_w [4][$];
    int exp_p [$];
    int hi_cnt [4];
    int cyc = 0;
    int last_fs = -1;

    servo_pwm_multi_if #(.CH_W(2)) m_if ();
    servo_pwm_multi_if #(.CH_W(2)) if3 ();

    servo_pwm_multi #(
        .NUM_CH(4), .PERIOD_CYCLES(P), .MIN_PULSE(100), .STEP_CYCLES(2), .CH_W(2)
    ) u_dut (
        .clk_i(clk), .reset_i(reset), .ena_i(ena), .slew_i(slew), .wr_if(m_if),
        .pwm_out_o(pwm), .frame_start_o(fs), .settled_o(settled)
    );

    servo_pwm_multi #(
        .NUM_CH(3), .PERIOD_CYCLES(P), .MIN_PULSE(100), .STEP_CYCLES(2), .CH_W(2)
    ) u_dut3 (
        .clk_i(clk), .reset_i(reset), .ena_i(ena), .slew_i(slew), .wr_if(if3),
        .pwm_out_o(pwm3), .frame_start_o(fs3), .settled_o(settled3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: measure each channel's high time and each frame's length in wall cycles.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
            last_fs = -1;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (pwm[c]) begin
                    hi_cnt[c]++;
                end else if (hi_cnt[c] > 0) begin
                    if (exp_w[c].size() == 0) chk($sformatf("unexpected_pulse_ch%0d", c), hi_cnt[c], 0);
                    else chk($sformatf("width_ch%0d", c), hi_cnt[c], exp_w[c].pop_front());
                    hi_cnt[c] = 0;
                end
            end
            if (fs) begin
                if (last_fs >= 0) begin
                    if (exp_p.size() == 0) chk("unexpected_frame", cyc - last_fs, 0);
                    else chk("frame_period", cyc - last_fs, exp_p.pop_front());
                end
                last_fs = cyc;
            end
        end
    end

    task automatic push_frame(input int w0, input int w1, input int w2, input int w3);
        exp_w[0].push_back(w0);
        exp_w[1].push_back(w1);
        exp_w[2].push_back(w2);
        exp_w[3].push_back(w3);
    endtask

    task automatic wait_fs();
        bit got = 1'b0;
        for (int i = 0; i < 1100 && !got; i++) begin
            @(negedge clk);
            if (fs) got = 1'b1;
        end
        if (!got) chk("frame_start_timeout", 0, 1);
    endtask

    task automatic wr(input bit u3, input int ch, input int pos);
        bit ok = 1'b0;
        bit rdy;
        @(negedge clk);
        if (u3) begin
            if3.wr_valid = 1'b1; if3.wr_ch = ch[1:0]; if3.wr_pos = pos[7:0];
        end else begin
            m_if.wr_valid = 1'b1; m_if.wr_ch = ch[1:0]; m_if.wr_pos = pos[7:0];
        end
        for (int i = 0; i < 5 && !ok; i++) begin
            rdy = u3 ? if3.wr_ready : m_if.wr_ready;
            @(negedge clk);
            if (rdy) ok = 1'b1;
        end
        m_if.wr_valid = 1'b0;
        if3.wr_valid  = 1'b0;
        if (!ok) chk("write_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1; ena = 1'b1; slew = 8'd0;
        m_if.wr_valid = 1'b0; m_if.wr_ch = '0; m_if.wr_pos = '0;
        if3.wr_valid  = 1'b0; if3.wr_ch  = '0; if3.wr_pos  = '0;

        repeat (3) @(negedge clk);
        chk("reset_ready", int'(m_if.wr_ready), 0);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_frame_start", int'(fs), 0);
        chk("reset_settled", int'(settled), 4'b1111);

        push_frame(100, 100, 100, 100);               // F1
        push_frame(100, 100, 100, 100);               // F2
        for (int i = 0; i < 9; i++) exp_p.push_back(P);
        exp_p.push_back(P + 37);                      // F10 stretched by ena low
        #2 reset = 1'b0;

        wait_fs();                                    // F1
        chk("ready_after_release", int'(m_if.wr_ready), 1);
        chk("settled_F1", int'(settled), 4'b1111);

        wait_fs();                                    // F2
        repeat (200) @(negedge clk);
        wr(1'b0, 1, 200);
        repeat (2) @(negedge clk);
        chk("settled_after_ch1_write", int'(settled), 4'b1101);
        wr(1'b1, 3, 255);
        repeat (2) @(negedge clk);
        chk("nch3_drop_ch3", int'(settled3), 3'b111);
        wr(1'b1, 2, 5);
        repeat (2) @(negedge clk);
        chk("nch3_write_ch2", int'(settled3), 3'b011);
        push_frame(100, 500, 100, 100);               // F3

        wait_fs();                                    // F3
        chk("settled_F3", int'(settled), 4'b1111);
        repeat (200) @(negedge clk);
        slew = 8'd30;
        wr(1'b0, 2, 100);
        repeat (2) @(negedge clk);
        chk("settled_after_ch2_write", int'(settled), 4'b1011);
        push_frame(100, 500, 160, 100);               // F4

        wait_fs();                                    // F4
        push_frame(100, 500, 220, 100);               // F5
        wait_fs();                                    // F5
        push_frame(100, 500, 280, 100);               // F6
        wait_fs();                                    // F6
        chk("settled_F6", int'(settled), 4'b1011);
        push_frame(100, 500, 300, 100);               // F7
        wait_fs();                                    // F7
        chk("settled_F7", int'(settled), 4'b1111);
        slew = 8'd0;
        push_frame(100, 500, 300, 100);               // F8

        // Present a write right on the boundary cycle and hold it.
        repeat (P - 2) @(negedge clk);                // counter = P-1
        m_if.wr_valid = 1'b1; m_if.wr_ch = 2'd0; m_if.wr_pos = 8'd50;
        chk("ready_boundary", int'(m_if.wr_ready), 0);
        @(negedge clk);                               // counter = 0
        chk("ready_after_boundary", int'(m_if.wr_ready), 1);
        chk("settled0_not_yet", int'(settled[0]), 1);
        @(negedge clk);
        m_if.wr_valid = 1'b0;
        @(negedge clk);
        chk("settled0_after_landing", int'(settled[0]), 0);

        repeat (100) @(negedge clk);
        wr(1'b0, 3, 255);
        wr(1'b0, 3, 10);
        push_frame(200, 500, 300, 120);               // F9

        wait_fs();                                    // F9
        push_frame(237, 537, 337, 157);               // F10

        wait_fs();                                    // F10
        repeat (50) @(negedge clk);
        ena = 1'b0;
        repeat (37) @(negedge clk);
        chk("pwm_held_ena_low", int'(pwm), 4'b1111);
        chk("fs_held_ena_low", int'(fs), 0);
        ena = 1'b1;

        wait_fs();                                    // F11
        repeat (50) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_pwm", int'(pwm), 0);
        chk("async_reset_ready", int'(m_if.wr_ready), 0);
        chk("async_reset_fs", int'(fs), 0);
        push_frame(100, 100, 100, 100);               // R1
        push_frame(100, 100, 100, 100);               // R2
        exp_p.push_back(P);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;

        wait_fs();                                    // R1
        chk("settled_after_reset", int'(settled), 4'b1111);
        wait_fs();                                    // R2
        repeat (300) @(negedge clk);
        for (int c = 0; c < 4; c++) chk($sformatf("pending_widths_ch%0d", c), exp_w[c].size(), 0);
        chk("pending_periods", exp_p.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
